pacman_move_ctrl: RTL and testbench

//  Sequences Pac-Man's tile-grid movement. Latches the player's one-hot switch direction,

---
 rtl/pacman_move_ctrl_pkg.sv | 47 ++++
 rtl/pacman_move_ctrl_if.sv | 28 ++
 rtl/pacman_move_ctrl_tick_gen.sv | 39 +++
 rtl/pacman_move_ctrl.sv | 158 +++++++++++++++
 tb/tb_pacman_move_ctrl.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pacman_move_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pacman_move_ctrl_pkg
// Definitions shared by the Pac-Man movement controller and its neighbours
// (ghost, level and graphics logic): heading codes, switch one-hot codes,
// coordinate width and the movement FSM state codes.
// ---------------------------------------------------------------------------
package pacman_move_ctrl_pkg;

  localparam int unsigned COORD_W = 5;

  // Heading codes as published on pac_dir
  localparam logic [1:0] DIR_LEFT  = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_UP    = 2'd2;
  localparam logic [1:0] DIR_DOWN  = 2'd3;

  // Raw SW[3:0] one-hot direction requests
  localparam logic [3:0] SW_LEFT  = 4'b1000;
  localparam logic [3:0] SW_RIGHT = 4'b0100;
  localparam logic [3:0] SW_UP    = 4'b0010;
  localparam logic [3:0] SW_DOWN  = 4'b0001;

  // Movement FSM state codes (legacy-compatible encoding)
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_CHK_TURN = 2'd1;
  localparam logic [1:0] ST_CHK_FWD  = 2'd2;
  localparam logic [1:0] ST_MOVE     = 2'd3;

  typedef logic [COORD_W-1:0] coord_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
  } tile_t;

  // Maps a one-hot switch pattern to a heading; callers qualify with $onehot.
  function automatic logic [1:0] sw_to_dir(input logic [3:0] sw);
    case (sw)
      SW_LEFT:  return DIR_LEFT;
      SW_RIGHT: return DIR_RIGHT;
      SW_UP:    return DIR_UP;
      SW_DOWN:  return DIR_DOWN;
      default:  return DIR_LEFT;
    endcase
  endfunction

endpackage

// File: rtl/pacman_move_ctrl_if.sv
// ---------------------------------------------------------------------------
// pacman_move_ctrl_if
// Wall-lookup port towards the shared maze RAM arbiter.
//   maze_req        requester -> arbiter : lookup request
//   maze_x, maze_y  requester -> arbiter : tile queried, stable while maze_req=1
//   maze_ack        arbiter -> requester : one-cycle grant
//   maze_wall       arbiter -> requester : 1 = wall, valid with maze_ack
// master = movement controller, slave = arbiter.
// ---------------------------------------------------------------------------
interface pacman_move_ctrl_if;
  import pacman_move_ctrl_pkg::*;

  logic   maze_req;
  coord_t maze_x;
  coord_t maze_y;
  logic   maze_ack;
  logic   maze_wall;

  modport master (
    output maze_req, maze_x, maze_y,
    input  maze_ack, maze_wall
  );

  modport slave (
    input  maze_req, maze_x, maze_y,
    output maze_ack, maze_wall
  );
endinterface

// File: rtl/pacman_move_ctrl_tick_gen.sv
// ---------------------------------------------------------------------------
// move_tick_gen
// Move-tick divider, also used by the ghost controllers.
//   clk_i     system clock
//   rst_i     synchronous active-high reset (count cleared)
//   enable_i  1 = count; 0 = hold the count, no tick
//   tick_o    one-cycle pulse on the cycle the count wraps TICK_DIV-1 -> 0
// ---------------------------------------------------------------------------
module move_tick_gen #(
  parameter int unsigned TICK_DIV = 2500000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic enable_i,
  output logic tick_o
);
  localparam int unsigned CNT_W = $clog2(TICK_DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wrap;

  assign wrap   = (cnt_q == CNT_W'(TICK_DIV - 1));
  assign tick_o = enable_i && wrap;

  always_comb begin
    cnt_d = cnt_q;
    if (enable_i) begin
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/pacman_move_ctrl.sv
// ---------------------------------------------------------------------------
// pacman_move_ctrl
// Sequences Pac-Man's tile-grid movement. Latches the one-hot switch request,
// checks the wall map over the shared maze port on each move tick and commits
// a turn, a straight-ahead move or a stop.
//   CLOCK_50   system clock (sole domain)
//   reset      synchronous active-high reset
//   dir_sw     raw SW[3:0]: 1000 LEFT, 0100 RIGHT, 0010 UP, 0001 DOWN
//   enable     1 = game running; 0 = tick frozen
//   maze       wall-lookup port (master side)
//   pac_x/y    current tile
//   pac_dir    heading: 0 LEFT, 1 RIGHT, 2 UP, 3 DOWN
//   moved      one-cycle pulse on the cycle pac_x/pac_y are committed
//   tick_miss  one-cycle pulse when a tick arrives while a move is in progress
// ---------------------------------------------------------------------------
module pacman_move_ctrl
  import pacman_move_ctrl_pkg::*;
#(
  parameter int unsigned COLS     = 28,
  parameter int unsigned ROWS     = 31,
  parameter int unsigned TICK_DIV = 2500000,
  parameter int unsigned START_X  = 13,
  parameter int unsigned START_Y  = 23
) (
  input  logic                   CLOCK_50,
  input  logic                   reset,
  input  logic [3:0]             dir_sw,
  input  logic                   enable,
  pacman_move_ctrl_if.master     maze,
  output logic [COORD_W-1:0]     pac_x,
  output logic [COORD_W-1:0]     pac_y,
  output logic [1:0]             pac_dir,
  output logic                   moved,
  output logic                   tick_miss
);

  // Adjacent tile in heading d; the maze edges wrap (tunnels).
  function automatic tile_t neighbour(input tile_t p, input logic [1:0] d);
    tile_t n;
    n = p;
    case (d)
      DIR_LEFT:  n.x = (p.x == '0) ? COORD_W'(COLS - 1) : p.x - 1'b1;
      DIR_RIGHT: n.x = (p.x == COORD_W'(COLS - 1)) ? '0 : p.x + 1'b1;
      DIR_UP:    n.y = (p.y == '0) ? COORD_W'(ROWS - 1) : p.y - 1'b1;
      default:   n.y = (p.y == COORD_W'(ROWS - 1)) ? '0 : p.y + 1'b1;
    endcase
    return n;
  endfunction

  logic       tick;
  logic [1:0] state_q,   state_d;
  tile_t      pos_q,     pos_d;
  logic [1:0] dir_q,     dir_d;
  logic [1:0] req_dir_q, req_dir_d;
  logic [1:0] try_dir_q, try_dir_d;
  tile_t      tgt_q,     tgt_d;
  logic       req_q,     req_d;

  move_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk_i    (CLOCK_50),
    .rst_i    (reset),
    .enable_i (enable),
    .tick_o   (tick)
  );

  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    dir_d     = dir_q;
    req_dir_d = req_dir_q;
    try_dir_d = try_dir_q;
    tgt_d     = tgt_q;
    req_d     = req_q;

    if ($onehot(dir_sw)) begin
      req_dir_d = sw_to_dir(dir_sw);
    end

    case (state_q)
      ST_IDLE: begin
        if (tick) begin
          // Target and direction are latched here so later switch changes
          // cannot disturb the lookup in flight.
          req_d = 1'b1;
          if (req_dir_q != dir_q) begin
            state_d   = ST_CHK_TURN;
            try_dir_d = req_dir_q;
            tgt_d     = neighbour(pos_q, req_dir_q);
          end else begin
            state_d   = ST_CHK_FWD;
            try_dir_d = dir_q;
            tgt_d     = neighbour(pos_q, dir_q);
          end
        end
      end
      ST_CHK_TURN: begin
        if (req_q && maze.maze_ack) begin
          req_d = 1'b0;
          if (maze.maze_wall) begin
            state_d   = ST_CHK_FWD;
            try_dir_d = dir_q;
            tgt_d     = neighbour(pos_q, dir_q);
          end else begin
            state_d = ST_MOVE;
          end
        end
      end
      ST_CHK_FWD: begin
        // Entered from a blocked turn with req low: one idle cycle on the
        // port before the forward request is raised.
        if (!req_q) begin
          req_d = 1'b1;
        end else if (maze.maze_ack) begin
          req_d   = 1'b0;
          state_d = maze.maze_wall ? ST_IDLE : ST_MOVE;
        end
      end
      default: begin
        pos_d   = tgt_q;
        dir_d   = try_dir_q;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pos_q.x   <= COORD_W'(START_X);
      pos_q.y   <= COORD_W'(START_Y);
      dir_q     <= DIR_LEFT;
      req_dir_q <= DIR_LEFT;
      try_dir_q <= DIR_LEFT;
      tgt_q     <= '0;
      req_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      dir_q     <= dir_d;
      req_dir_q <= req_dir_d;
      try_dir_q <= try_dir_d;
      tgt_q     <= tgt_d;
      req_q     <= req_d;
    end
  end

  assign maze.maze_req = req_q;
  assign maze.maze_x   = tgt_q.x;
  assign maze.maze_y   = tgt_q.y;
  assign pac_x         = pos_q.x;
  assign pac_y         = pos_q.y;
  assign pac_dir       = dir_q;
  assign moved         = (state_q == ST_MOVE);
  assign tick_miss     = tick && (state_q != ST_IDLE);

endmodule

// File: tb/tb_pacman_move_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pacman_move_ctrl
// Randomized bench: acts as the maze arbiter over a wall map held in an
// array, and predicts every cycle from a transaction-level model (tick count,
// queue of candidate headings per move, modulo tile arithmetic).
// ---------------------------------------------------------------------------
module tb_pacman_move_ctrl;
  import pacman_move_ctrl_pkg::*;

  localparam int COLS = 28;
  localparam int ROWS = 31;
  localparam int TDIV = 8;
  localparam int SX   = 13;
  localparam int SY   = 23;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [3:0] dir_sw = 4'b0000;
  logic [4:0] pac_x, pac_y;
  logic [1:0] pac_dir;
  logic       moved, tick_miss;

  pacman_move_ctrl_if mif();

  always #5 clk = ~clk;

  pacman_move_ctrl #(
    .COLS     (COLS),
    .ROWS     (ROWS),
    .TICK_DIV (TDIV),
    .START_X  (SX),
    .START_Y  (SY)
  ) dut (
    .CLOCK_50  (clk),
    .reset     (reset),
    .dir_sw    (dir_sw),
    .enable    (enable),
    .maze      (mif),
    .pac_x     (pac_x),
    .pac_y     (pac_y),
    .pac_dir   (pac_dir),
    .moved     (moved),
    .tick_miss (tick_miss)
  );

  int n_checks = 0;
  int n_fail   = 0;

  bit maze [COLS][ROWS];

  // reference model state
  int m_x, m_y, m_dir, m_req, m_cnt;
  bit m_busy, m_gap, m_movep;
  int dirs [$];
  int t_x, t_y, t_dir;

  // stimulus policy
  int         sw_mode;
  logic [3:0] sw_fixed;
  int         en_mode;
  int         ack_max;
  bit         ack_hold, spur, rst_drv;
  int         wait_left;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void nb(input int x, input int y, input int d, output int nx, output int ny);
    nx = x;
    ny = y;
    case (d)
      0:       nx = (x + COLS - 1) % COLS;
      1:       nx = (x + 1) % COLS;
      2:       ny = (y + ROWS - 1) % ROWS;
      default: ny = (y + 1) % ROWS;
    endcase
  endfunction

  function automatic int sw_dir_model(input logic [3:0] sw);
    case (sw)
      4'b1000: return 0;
      4'b0100: return 1;
      4'b0010: return 2;
      4'b0001: return 3;
      default: return -1;
    endcase
  endfunction

  function automatic bit maze_at(input int x, input int y);
    if (x < COLS && y < ROWS) return maze[x][y];
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_x = SX; m_y = SY; m_dir = 0; m_req = 0; m_cnt = 0;
    m_busy = 0; m_gap = 0; m_movep = 0;
    dirs.delete();
  endtask

  task automatic set_maze(input int pct);
    for (int i = 0; i < COLS; i++)
      for (int j = 0; j < ROWS; j++)
        maze[i][j] = ($urandom_range(0, 99) < pct);
  endtask

  task automatic step();
    int  r, d, cand, nx, ny;
    bit  ack_drv, exp_tick, busy_next;
    @(posedge clk);
    #1;
    reset = rst_drv;
    if (sw_mode == 0) begin
      dir_sw = sw_fixed;
    end else begin
      r = $urandom_range(0, 9);
      if (r < 6)      dir_sw = 4'b0001 << $urandom_range(0, 3);
      else if (r < 8) dir_sw = 4'b0000;
      else            dir_sw = 4'($urandom);
    end
    case (en_mode)
      0:       enable = 1'b1;
      1:       enable = ($urandom_range(0, 9) < 8);
      default: enable = 1'b0;
    endcase
    ack_drv = 0;
    mif.maze_ack  = 1'b0;
    mif.maze_wall = 1'b0;
    if (mif.maze_req === 1'b1) begin
      if (!ack_hold) begin
        if (wait_left == 0) begin
          ack_drv = 1;
          mif.maze_ack  = 1'b1;
          mif.maze_wall = maze_at(int'(mif.maze_x), int'(mif.maze_y));
          wait_left = $urandom_range(0, ack_max);
        end else begin
          wait_left--;
        end
      end
    end else if (spur && $urandom_range(0, 3) == 0) begin
      mif.maze_ack  = 1'b1;
      mif.maze_wall = 1'($urandom_range(0, 1));
    end
    #1;
    exp_tick  = enable && (m_cnt == TDIV - 1);
    busy_next = m_busy;
    check_eq("tick_miss", tick_miss, exp_tick && m_busy);
    check_eq("pac_x", pac_x, m_x);
    check_eq("pac_y", pac_y, m_y);
    check_eq("pac_dir", pac_dir, m_dir);
    if (!m_busy) begin
      check_eq("req_idle", mif.maze_req, 0);
      check_eq("moved_idle", moved, 0);
      if (exp_tick) begin
        dirs.delete();
        if (m_req != m_dir) dirs.push_back(m_req);
        dirs.push_back(m_dir);
        busy_next = 1;
      end
    end else if (m_movep) begin
      check_eq("moved", moved, 1);
      check_eq("req_move", mif.maze_req, 0);
      m_x = t_x; m_y = t_y; m_dir = t_dir;
      m_movep   = 0;
      busy_next = 0;
    end else if (m_gap) begin
      check_eq("req_gap", mif.maze_req, 0);
      check_eq("moved_gap", moved, 0);
      m_gap = 0;
    end else begin
      check_eq("req_lookup", mif.maze_req, 1);
      check_eq("moved_lookup", moved, 0);
      cand = dirs[0];
      nb(m_x, m_y, cand, nx, ny);
      check_eq("maze_x", mif.maze_x, nx);
      check_eq("maze_y", mif.maze_y, ny);
      if (ack_drv) begin
        void'(dirs.pop_front());
        if (!maze_at(nx, ny)) begin
          m_movep = 1; t_x = nx; t_y = ny; t_dir = cand;
        end else if (dirs.size() > 0) begin
          m_gap = 1;
        end else begin
          busy_next = 0;
        end
      end
    end
    m_busy = busy_next;
    if (enable) m_cnt = (m_cnt + 1) % TDIV;
    d = sw_dir_model(dir_sw);
    if (d >= 0) m_req = d;
    if (rst_drv) model_reset();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst_drv = 1; en_mode = 2;
    run(2);
    rst_drv = 0;
  endtask

  initial begin
    bit found;
    mif.maze_ack  = 1'b0;
    mif.maze_wall = 1'b0;
    model_reset();
    sw_mode = 0; sw_fixed = 4'b0000; en_mode = 2; ack_max = 2;
    ack_hold = 0; spur = 1; rst_drv = 1; wait_left = 0;
    set_maze(0);
    do_reset();

    // open corridor, each heading held long enough to cross a tunnel
    en_mode = 0;
    sw_fixed = 4'b0100; run(220);
    sw_fixed = 4'b1000; run(280);
    sw_fixed = 4'b0010; run(300);
    sw_fixed = 4'b0001; run(300);

    // slow arbiter: grants outlast the tick period
    ack_max = 12; sw_mode = 1; run(300);

    // dead ends everywhere
    set_maze(100); ack_max = 2; run(100);

    // random maze, random switches, random enable
    set_maze(35); en_mode = 1; ack_max = 10; run(2000);

    // reset while a turn lookup is waiting for its grant
    set_maze(0); ack_max = 2; sw_mode = 0; sw_fixed = 4'b0000;
    do_reset();
    en_mode = 0; sw_fixed = 4'b0010; ack_hold = 1;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (m_busy && !m_gap && !m_movep && dirs.size() == 2 && mif.maze_req === 1'b1)
        found = 1;
    end
    check_eq("rst_mid_reach", found, 1);
    rst_drv = 1; step();
    rst_drv = 0; ack_hold = 0; sw_fixed = 4'b0011;
    step();
    check_eq("rst_mid_req", mif.maze_req, 0);
    check_eq("rst_mid_dir", pac_dir, 0);
    run(60);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
